// File: rtl/lane_accumulator_pkg.sv
// Shared lane geometry, per-lane FSM encoding and helpers for the lane
// accumulator and the value fetcher that feeds it.
package lane_accumulator_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned PC_W  = $clog2(LANES + 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } lane_state_e;

  // Extract lane idx from a packed multi-lane value bus.
  function automatic logic [VAL_W-1:0] lane_slice(input logic [LANES*VAL_W-1:0] bus,
                                                  input int unsigned idx);
    return bus[idx*VAL_W +: VAL_W];
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lane_accumulator_lane.sv
// One accumulator lane: pops values from a FWFT source, sums ROW_LEN of them
// and holds the row sum under a valid/ready handshake.
module acc_lane
  import lane_accumulator_pkg::*;
#(
  parameter int unsigned ROW_LEN = 8,
  parameter int unsigned ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] val_i,
  input  logic             empty_i,
  input  logic             res_ready_i,
  output logic             pop_c_o,
  output logic [ACC_W-1:0] res_o,
  output logic             res_valid_o,
  output logic             busy_o
);

  localparam int unsigned CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROW_LEN - 1);

  lane_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             pop;
  logic [ACC_W-1:0] val_ext;

  assign val_ext = ACC_W'(val_i);

  // Next-state, pop strobe and datapath updates.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    count_d = count_q;
    valid_d = valid_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_ACCUM: begin
        pop = ~empty_i & ~rst;
        if (pop) begin
          if (count_q == LAST) begin
            res_d   = acc_q + val_ext;
            valid_d = 1'b1;
            acc_d   = '0;
            count_d = '0;
            state_d = ST_HOLD;
          end else begin
            acc_d   = acc_q + val_ext;
            count_d = count_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        pop = res_ready_i & ~empty_i & ~rst;
        if (res_ready_i) begin
          // A single-value row completes on the very pop that releases it.
          if (pop && (ROW_LEN == 1)) begin
            res_d = val_ext;
          end else if (pop) begin
            acc_d   = val_ext;
            count_d = CW'(1);
            valid_d = 1'b0;
            state_d = ST_ACCUM;
          end else begin
            valid_d = 1'b0;
            state_d = ST_ACCUM;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      res_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign pop_c_o     = pop;
  assign res_o       = res_q;
  assign res_valid_o = valid_q;
  assign busy_o      = (count_q != '0) | valid_q;

endmodule

// File: rtl/lane_accumulator.sv
// Multi-lane row-sum accumulator between the value fetcher and writeback;
// lanes run independently, the top only packs buses and counts accepted rows.
module lane_accumulator
  import lane_accumulator_pkg::*;
#(
  parameter int unsigned ROW_LEN = 8,
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*VAL_W-1:0] val_in,
  input  logic [LANES-1:0]       empty,
  output logic [LANES-1:0]       val_read,
  output logic [LANES*ACC_W-1:0] res_out,
  output logic [LANES-1:0]       res_valid,
  input  logic [LANES-1:0]       res_ready,
  output logic [CNT_W-1:0]       rows_done,
  output logic                   busy
);

  logic [LANES-1:0] lane_busy;
  logic [CNT_W-1:0] rows_q, rows_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    acc_lane #(
      .ROW_LEN(ROW_LEN),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .val_i      (lane_slice(val_in, i)),
      .empty_i    (empty[i]),
      .res_ready_i(res_ready[i]),
      .pop_c_o    (val_read[i]),
      .res_o      (res_out[i*ACC_W +: ACC_W]),
      .res_valid_o(res_valid[i]),
      .busy_o     (lane_busy[i])
    );
  end

  // Every lane handing off a result this cycle counts as one finished row.
  always_comb begin
    rows_d = rows_q + CNT_W'(popcount(res_valid & res_ready));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q <= '0;
    end else begin
      rows_q <= rows_d;
    end
  end

  assign rows_done = rows_q;
  assign busy      = |lane_busy;

endmodule
